// File: rtl/mult_sched_pkg.sv
// Shared defaults and types for the time-shared multi17 scheduler.
package mult_sched_pkg;

    localparam int unsigned N_REQ_DEF    = 4;
    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned A_W_DEF      = 17;
    localparam int unsigned B_W_DEF      = 8;
    localparam int unsigned TAG_W        = $clog2(N_REQ_DEF);

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_e;

    // One slot of the latency-matched tag pipeline at the default requester count.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_stage_t;

endpackage

// File: rtl/sched_rr_arb.sv
// Single-grant arbiter: round-robin from a pointer, or fixed priority with index 0 highest.
module sched_rr_arb
    import mult_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned TW    = TAG_W
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [TW-1:0]    i_ptr,
    input  prio_e            i_mode,
    output logic [N_REQ-1:0] o_grant,
    output logic [TW-1:0]    o_idx,
    output logic             o_any
);

    logic [TW-1:0] w_j;

    // Scan candidates in priority order; the first requesting one wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (i_mode == PRIO_FIXED) begin
                w_j = TW'(k);
            end else begin
                w_j = TW'((32'(i_ptr) + k) % N_REQ);
            end
            if (!o_any && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one multi17 pipeline among N_REQ requesters; tags ride a matched shift pipeline back.
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter  int unsigned N_REQ    = N_REQ_DEF,
    parameter  int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter  int unsigned A_W      = A_W_DEF,
    parameter  int unsigned B_W      = B_W_DEF,
    localparam int unsigned TW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 prio_mode,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic [A_W-1:0]       mul_a,
    output logic [B_W-1:0]       mul_b,
    input  logic [A_W-1:0]       mul_p,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [TW-1:0]        rsp_tag,
    output logic [A_W-1:0]       rsp_data,
    output logic                 busy
);

    localparam int unsigned N_STG = MULT_LAT + 1;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
    } stage_t;

    prio_e            w_mode;
    logic [N_REQ-1:0] w_req;
    logic [N_REQ-1:0] w_grant;
    logic [TW-1:0]    w_idx;
    logic             w_fire;
    logic [TW-1:0]    r_ptr;
    logic [A_W-1:0]   r_mul_a;
    logic [B_W-1:0]   r_mul_b;
    stage_t           r_stg [N_STG];
    stage_t           w_last;
    logic [N_REQ-1:0] r_pend;

    assign w_mode = prio_e'(prio_mode);
    // Grants are suppressed while reset is held so no launch can slip in during reset.
    assign w_req  = (en && rst_n) ? req_valid : '0;

    sched_rr_arb #(
        .N_REQ (N_REQ),
        .TW    (TW)
    ) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_mode  (w_mode),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_fire)
    );

    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_fire) begin
            r_mul_a <= req_a[w_idx*A_W +: A_W];
            r_mul_b <= req_b[w_idx*B_W +: B_W];
        end
    end

    assign mul_a = r_mul_a;
    assign mul_b = r_mul_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_fire && (w_mode == PRIO_RR)) begin
            r_ptr <= (w_idx == TW'(N_REQ - 1)) ? '0 : w_idx + TW'(1);
        end
    end

    // Free-running shift: stage N_STG-1 lines up with the multiplier output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < N_STG; s++) begin
                r_stg[s] <= '0;
            end
        end else begin
            r_stg[0] <= '{valid: w_fire, tag: w_idx};
            for (int unsigned s = 1; s < N_STG; s++) begin
                r_stg[s] <= r_stg[s-1];
            end
        end
    end

    assign w_last   = r_stg[N_STG-1];
    assign rsp_data = mul_p;

    always_comb begin
        rsp_valid = '0;
        rsp_tag   = '0;
        if (w_last.valid) begin
            rsp_valid[w_last.tag] = 1'b1;
            rsp_tag               = w_last.tag;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s < N_STG; s++) begin
            busy = busy | r_stg[s].valid;
        end
    end

    // Lanes that were requesting without a grant last edge must still be requesting now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= req_valid & ~w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ((r_pend & ~req_valid) == '0)
                else $error("req_valid withdrawn before handshake: %b", r_pend & ~req_valid);
            assert ($onehot0(rsp_valid))
                else $error("rsp_valid not one-hot: %b", rsp_valid);
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed and randomised checks of mult_share_sched against a scoreboard and a mock multi17.
module tb_mult_share_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        prio_mode = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [67:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [16:0] mul_a;
    logic [7:0]  mul_b;
    logic [16:0] mul_p;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_tag;
    logic [16:0] rsp_data;
    logic        busy;

    always #5 clk = ~clk;

    mult_share_sched #(
        .N_REQ    (4),
        .MULT_LAT (4),
        .A_W      (17),
        .B_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .prio_mode (prio_mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Q1.16 x Q1.7 sign-magnitude product, truncated toward zero.
    function automatic logic [16:0] mulf(input logic [16:0] a, input logic [7:0] b);
        logic [16:0] ma;
        logic [7:0]  mb;
        logic [24:0] p;
        logic [16:0] m;
        ma = a[16] ? -a : a;
        mb = b[7] ? -b : b;
        p  = ma * mb;
        m  = p[23:7];
        return (a[16] ^ b[7]) ? -m : m;
    endfunction

    // Mock four-cycle multiplier sharing rst_n.
    logic [16:0] mp [4];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) mp[s] <= '0;
        end else begin
            mp[0] <= mulf(mul_a, mul_b);
            for (int s = 1; s < 4; s++) mp[s] <= mp[s-1];
        end
    end
    assign mul_p = mp[3];

    typedef struct {
        int          tag;
        logic [16:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    logic [3:0]  keep = '0;
    logic [3:0]  last_hs = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_grant(input logic [3:0] v, input logic e, input logic r,
                                             input logic m, input int p);
        int idx;
        if (!(e && r)) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx = m ? k : (p + k) % 4;
            if (v[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    task automatic set_lane(input int i, input logic [16:0] a, input logic [7:0] b);
        req_valid[i]        = 1'b1;
        req_a[i*17 +: 17]   = a;
        req_b[i*8 +: 8]     = b;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic mon();
        logic [3:0] hs;
        exp_t       e;
        chk("grant", 32'(req_ready), 32'(ref_grant(req_valid, en, rst_n, prio_mode, m_ptr)));
        hs      = req_valid & req_ready;
        last_hs = hs;
        if (rsp_valid !== 4'b0000 || (sbq.size() > 0 && sbq[0].due == cyc)) begin
            if (sbq.size() == 0) begin
                chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_cycle", cyc, e.due);
                chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.tag));
                chk("rsp_tag", 32'(rsp_tag), e.tag);
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                e.tag  = i;
                e.data = mulf(req_a[i*17 +: 17], req_b[i*8 +: 8]);
                e.due  = cyc + 5;
                sbq.push_back(e);
                if (!prio_mode) m_ptr = (i + 1) % 4;
            end
        end
    endtask

    task automatic step();
        #1;
        mon();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (last_hs[i] && keep[i]) begin
                req_a[i*17 +: 17] = 17'($urandom);
                req_b[i*8 +: 8]   = 8'($urandom);
            end
        end
        req_valid = req_valid & ~(last_hs & ~keep);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_mul_a"}, 32'(mul_a), 32'd0);
        chk({name, "_mul_b"}, 32'(mul_b), 32'd0);
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({name, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        en = 1'b1;
        @(negedge clk);
        settle();
        chk_reset_outputs("reset");
        step();
        step();
        rst_n = 1'b1;

        // single request on lane 2
        set_lane(2, 17'h04000, 8'h40);
        settle();
        chk("t1_ready", 32'(req_ready), 32'h4);
        step();
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_mul_a", 32'(mul_a), 32'h04000);
            chk("t1_mul_b", 32'(mul_b), 32'h40);
            if (k < 5) begin
                chk("t1_quiet", 32'(rsp_valid), 32'd0);
            end else begin
                chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
                chk("t1_rsp_tag", 32'(rsp_tag), 32'd2);
                chk("t1_rsp_data", 32'(rsp_data), 32'h02000);
            end
            step();
        end
        settle();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_rsp", 32'(rsp_valid), 32'd0);

        // lane 3 alone moves the pointer back to 0
        set_lane(3, 17'h00100, 8'h7f);
        settle();
        chk("align_ready", 32'(req_ready), 32'h8);
        repeat (7) step();

        // round-robin with all lanes busy
        for (int i = 0; i < 4; i++) set_lane(i, 17'($urandom), 8'($urandom));
        keep = 4'hF;
        for (int k = 0; k < 12; k++) begin
            settle();
            chk("t2_rr", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k == 8) keep = 4'h0;
            step();
        end
        repeat (6) step();
        settle();
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_drained", sbq.size(), 0);

        // fixed priority starves lane 3, round-robin then serves it
        prio_mode = 1'b1;
        set_lane(1, 17'h1FFFF, 8'h80);
        set_lane(3, 17'h0AAAA, 8'h55);
        keep = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t3_fixed", 32'(req_ready), 32'h2);
            step();
        end
        prio_mode = 1'b0;
        settle();
        chk("t3_rr_a", 32'(req_ready), 32'h2);
        step();
        settle();
        chk("t3_rr_b", 32'(req_ready), 32'h8);
        step();
        keep = 4'h0;
        settle();
        chk("t3_rr_c", 32'(req_ready), 32'h2);
        repeat (7) step();
        settle();
        chk("t3_busy", 32'(busy), 32'd0);

        // en dropped after two launches
        set_lane(0, 17'h10000, 8'h7f);
        set_lane(1, 17'h0FFFF, 8'h81);
        set_lane(2, 17'h12345, 8'h33);
        settle();
        chk("t4_first", 32'(req_ready), 32'h4);
        step();
        settle();
        chk("t4_second", 32'(req_ready), 32'h1);
        step();
        en = 1'b0;
        for (int j = 0; j <= 5; j++) begin
            settle();
            chk("t4_blocked", 32'(req_ready), 32'd0);
            chk("t4_busy", 32'(busy), 32'(j <= 4));
            step();
        end
        en = 1'b1;
        settle();
        chk("t4_resume", 32'(req_ready), 32'h2);
        repeat (7) step();

        // reset mid-flight discards three launches
        set_lane(0, 17'h00FFF, 8'h10);
        set_lane(1, 17'h1F000, 8'h20);
        set_lane(3, 17'h05555, 8'hF0);
        settle();
        chk("t5_g0", 32'(req_ready), 32'h8);
        step();
        settle();
        chk("t5_g1", 32'(req_ready), 32'h1);
        step();
        settle();
        chk("t5_g2", 32'(req_ready), 32'h2);
        step();
        step();
        step();
        rst_n = 1'b0;
        sbq.delete();
        m_ptr = 0;
        settle();
        chk_reset_outputs("t5_rst");
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("t5_no_stale", 32'(rsp_valid), 32'd0);
            chk("t5_busy", 32'(busy), 32'd0);
            step();
        end
        set_lane(1, 17'h1C000, 8'h40);
        settle();
        chk("t5_ready", 32'(req_ready), 32'h2);
        step();
        for (int k = 1; k <= 5; k++) begin
            settle();
            if (k < 5) begin
                chk("t5_quiet", 32'(rsp_valid), 32'd0);
            end else begin
                chk("t5_rsp_valid", 32'(rsp_valid), 32'h2);
                chk("t5_rsp_tag", 32'(rsp_tag), 32'd1);
                chk("t5_rsp_data", 32'(rsp_data), 32'h1E000);
            end
            step();
        end

        // random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1))
                    set_lane(i, 17'($urandom), 8'($urandom));
            end
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) prio_mode = ~prio_mode;
            step();
        end
        en = 1'b1;
        prio_mode = 1'b0;
        for (int g = 0; g < 100 && (req_valid != 4'h0 || sbq.size() != 0); g++) step();
        settle();
        chk("drain_valid", 32'(req_valid), 32'd0);
        chk("drain_sbq", sbq.size(), 0);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
